// File: rtl/sync_r2w_ptr.sv
// Read-to-write Gray pointer synchroniser with binary conversion and write-side occupancy.
// Optional Gray-sequence checker enabled by defining SYNC_R2W_GRAY_CHECK_EN.
module sync_r2w_ptr #(
  parameter int unsigned ADDRSIZE    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic [ADDRSIZE:0] rptr,
  input  logic [ADDRSIZE:0] wbin,
  input  logic              werr_clr,
  output logic [ADDRSIZE:0] wq_rptr,
  output logic [ADDRSIZE:0] wq_rbin,
  output logic [ADDRSIZE:0] wfill,
  output logic              wsync_valid,
  output logic              wgray_err
);

  localparam int unsigned PW = ADDRSIZE + 1;
  localparam logic [2:0] PrimeMax = 3'(SYNC_STAGES + 2);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("sync_r2w_ptr: SYNC_STAGES must be in 2..4");
  end

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rbin_d;
  logic [PW-1:0] rbin_q;
  logic [PW-1:0] fill_q;
  logic [2:0]    cnt_q;

  // Plain flop chain: no logic between stages so each bit resolves metastability independently.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rptr;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wq_rptr = sync_q[SYNC_STAGES-1];

  // Binary bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    rbin_d = '0;
    for (int i = 0; i < int'(PW); i++) rbin_d[i] = ^(wq_rptr >> i);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rbin_q <= '0;
      fill_q <= '0;
    end else begin
      rbin_q <= rbin_d;
      fill_q <= wbin - rbin_q;
    end
  end

  assign wq_rbin = rbin_q;
  assign wfill   = fill_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      cnt_q <= '0;
    end else if (cnt_q != PrimeMax) begin
      cnt_q <= cnt_q + 3'd1;
    end
  end

  assign wsync_valid = (cnt_q == PrimeMax);

`ifdef SYNC_R2W_GRAY_CHECK_EN
  logic [PW-1:0] prev_q;
  logic          err_q;
  logic          err_d;

  // Set has priority over clear so a violation is never lost.
  always_comb begin
    err_d = err_q;
    if (werr_clr) err_d = 1'b0;
    if (wsync_valid && ($countones(wq_rptr ^ prev_q) > 1)) err_d = 1'b1;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= wq_rptr;
      err_q  <= err_d;
    end
  end

  assign wgray_err = err_q;
`else
  logic unused_werr_clr;
  assign unused_werr_clr = werr_clr;
  assign wgray_err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_r2w_ptr.sv
// Randomised bench for sync_r2w_ptr: a history-based model predicts every output each cycle,
// with directed literal checks for reset, latency, wrap, full/empty, Gray errors and mid-op reset.
module tb_sync_r2w_ptr;
  localparam int AW = 4;
  localparam int S  = 2;
  localparam int PW = AW + 1;
`ifdef SYNC_R2W_GRAY_CHECK_EN
  localparam int GCHK = 1;
`else
  localparam int GCHK = 0;
`endif

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b0;
  logic          werr_clr = 1'b0;
  logic [PW-1:0] rptr = '0;
  logic [PW-1:0] wbin = '0;
  logic [PW-1:0] wq_rptr, wq_rbin, wfill;
  logic          wsync_valid, wgray_err;

  sync_r2w_ptr #(.ADDRSIZE(AW), .SYNC_STAGES(S)) dut (
    .wclk       (wclk),
    .wrst_n     (wrst_n),
    .rptr       (rptr),
    .wbin       (wbin),
    .werr_clr   (werr_clr),
    .wq_rptr    (wq_rptr),
    .wq_rbin    (wq_rbin),
    .wfill      (wfill),
    .wsync_valid(wsync_valid),
    .wgray_err  (wgray_err)
  );

  always #5 wclk = ~wclk;

  int n_chk  = 0;
  int n_fail = 0;
  bit [PW-1:0] rh[$];  // rptr sampled at each post-reset edge
  bit [PW-1:0] wh[$];  // wbin sampled at each post-reset edge
  bit err_m = 1'b0;
  bit chk_en = 1'b0;

  function automatic bit [PW-1:0] b2g(input bit [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Inverse Gray by exhaustive search over the code space.
  function automatic bit [PW-1:0] g2b(input bit [PW-1:0] g);
    bit [PW-1:0] b = '0;
    for (int v = 0; v < (1 << PW); v++) begin
      bit [PW-1:0] vv;
      vv = PW'(v);
      if (b2g(vv) == g) b = vv;
    end
    return b;
  endfunction

  // Expected outputs after j post-reset edges.
  function automatic bit [PW-1:0] exp_wq(input int j);
    if (j >= S && (j - S) < rh.size()) return rh[j-S];
    return '0;
  endfunction

  function automatic bit [PW-1:0] exp_rbin(input int j);
    return g2b(exp_wq(j - 1));
  endfunction

  function automatic bit [PW-1:0] exp_fill(input int j);
    if (j >= 1 && (j - 1) < wh.size()) return wh[j-1] - exp_rbin(j - 1);
    return '0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge wrst_n) begin
    rh.delete();
    wh.delete();
    err_m = 1'b0;
  end

  always @(posedge wclk) begin
    int k;
    if (wrst_n) begin
      k = rh.size();
      if (GCHK != 0 && k >= S + 2 && $countones(exp_wq(k) ^ exp_wq(k - 1)) > 1) err_m = 1'b1;
      else if (werr_clr) err_m = 1'b0;
      rh.push_back(rptr);
      wh.push_back(wbin);
    end
  end

  always @(negedge wclk) begin
    int k;
    if (chk_en) begin
      k = rh.size();
      chk("m_wq_rptr", int'(wq_rptr), int'(exp_wq(k)));
      chk("m_wq_rbin", int'(wq_rbin), int'(exp_rbin(k)));
      chk("m_wfill", int'(wfill), int'(exp_fill(k)));
      chk("m_wsync_valid", int'(wsync_valid), (k >= S + 2) ? 1 : 0);
      chk("m_wgray_err", int'(wgray_err), int'(err_m));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge wclk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_wq_rptr"}, int'(wq_rptr), 0);
    chk({nm, "_wq_rbin"}, int'(wq_rbin), 0);
    chk({nm, "_wfill"}, int'(wfill), 0);
    chk({nm, "_valid"}, int'(wsync_valid), 0);
    chk({nm, "_err"}, int'(wgray_err), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int wrap_bin [5] = '{29, 30, 31, 0, 1};
    int wrap_fill[5] = '{5, 4, 3, 2, 1};
    bit [PW-1:0] rb;

    chk_en = 1'b1;
    // Reset with a non-zero pointer present.
    rptr = b2g(5'd27);
    wbin = 5'd3;
    tick(2);
    chk_zero("rst");
    wrst_n = 1'b1;
    for (int e = 1; e <= S + 2; e++) begin
      tick(1);
      chk("rst_valid", int'(wsync_valid), (e == S + 2) ? 1 : 0);
    end
    chk("rst_rbin", int'(wq_rbin), 27);
    chk("rst_fill", int'(wfill), 8);

    // Latency of a single Gray step.
    wbin = 5'd8;
    rptr = b2g(5'd0);
    tick(S + 3);
    rptr = b2g(5'd1);
    for (int e = 1; e <= S + 2; e++) begin
      tick(1);
      chk("lat_wq_rptr", int'(wq_rptr), (e >= S) ? 1 : 0);
      chk("lat_wq_rbin", int'(wq_rbin), (e >= S + 1) ? 1 : 0);
      chk("lat_wfill", int'(wfill), (e >= S + 2) ? 7 : 8);
    end

    // Legal walk up to 28, then across the wrap.
    for (int b = 2; b <= 28; b++) begin
      rptr = b2g(PW'(b));
      tick(1);
    end
    wbin = 5'd2;
    for (int i = 0; i < 5; i++) begin
      rptr = b2g(PW'(wrap_bin[i]));
      tick(S + 2);
      chk("wrap_rbin", int'(wq_rbin), wrap_bin[i]);
      chk("wrap_fill", int'(wfill), wrap_fill[i]);
      chk("wrap_err", int'(wgray_err), 0);
    end

    // Full and empty.
    wbin = 5'd16;
    rptr = b2g(5'd0);
    tick(S + 2);
    chk("full_fill", int'(wfill), 16);
    for (int b = 1; b <= 9; b++) begin
      rptr = b2g(PW'(b));
      tick(1);
    end
    wbin = 5'd9;
    tick(S + 2);
    chk("empty_fill", int'(wfill), 0);

    // Gray violation, clear, and clear colliding with a new violation.
    for (int b = 8; b >= 0; b--) begin
      rptr = b2g(PW'(b));
      tick(1);
    end
    tick(S + 2);
    rptr = 5'b00011;
    for (int e = 1; e <= S + 1; e++) begin
      tick(1);
      chk("gerr_set", int'(wgray_err), (e == S + 1) ? GCHK : 0);
    end
    tick(2);
    chk("gerr_hold", int'(wgray_err), GCHK);
    werr_clr = 1'b1;
    tick(1);
    werr_clr = 1'b0;
    chk("gerr_clr", int'(wgray_err), 0);
    rptr = 5'b11000;
    tick(S);
    werr_clr = 1'b1;
    tick(1);
    werr_clr = 1'b0;
    chk("gerr_set_wins", int'(wgray_err), GCHK);
    werr_clr = 1'b1;
    tick(1);
    werr_clr = 1'b0;
    chk("gerr_clr2", int'(wgray_err), 0);

    // Mid-operation reset while stepping.
    rb = g2b(rptr);
    for (int i = 0; i < 5; i++) begin
      rb = rb + 1'b1;
      rptr = b2g(rb);
      tick(1);
    end
    #2 wrst_n = 1'b0;
    #1 chk_zero("midrst");
    tick(1);
    wrst_n = 1'b1;
    for (int e = 1; e <= S + 2; e++) begin
      rb = rb + 1'b1;
      rptr = b2g(rb);
      tick(1);
      chk("midrst_valid", int'(wsync_valid), (e == S + 2) ? 1 : 0);
      chk("midrst_err", int'(wgray_err), 0);
    end

    // Random legal traffic with occasional reset and clear pulses; model checks every cycle.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(3) == 0) rb = rb + 1'b1;
      rptr = b2g(rb);
      wbin = PW'($urandom);
      werr_clr = ($urandom_range(15) == 0);
      if ($urandom_range(299) == 0) begin
        #2 wrst_n = 1'b0;
        tick(1);
        wrst_n = 1'b1;
      end else begin
        tick(1);
      end
    end
    werr_clr = 1'b0;
    tick(2);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
